// File: rtl/bcd_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor_pkg
// Purpose  : Shared FSM encoding, BCD constants and digit helper for the
//            digit-serial BCD subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_BASE = 4'd10;

  // True when a nibble is a legal decimal digit
  function automatic logic bcd_digit_ok(input logic [3:0] dig);
    return (dig <= BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor_if
// Purpose  : Start/done handshake and operand/result bus of the serial BCD
//            subtractor. master = controlling FSM, slave = subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
  logic                  err;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, err
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_sub
// Purpose  : Combinational single-digit BCD subtract with borrow:
//            {bout, d} = a - b - bin, d corrected back into 0..9.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] w_t;

  // Binary difference; bit 4 set means negative, so add ten back and borrow
  always_comb begin
    w_t  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    bout = w_t[4];
    d    = w_t[4] ? (w_t[3:0] + BCD_BASE) : w_t[3:0];
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_subtractor
// Purpose  : Digit-serial multi-digit BCD subtractor, diff = a - b - bin,
//            least significant digit first, one digit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int                  c_width    = 4 * DIGITS;
  localparam int                  c_idx_w    = $clog2(DIGITS) + 1;
  localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(DIGITS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_width-1:0]   r_a;
  logic [c_width-1:0]   r_b;
  logic [c_width-1:0]   r_diff;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_borrow;
  logic                 r_bout;
  logic                 r_err;

  logic                 w_bad;
  logic                 w_accept;
  logic                 w_last;
  logic [3:0]           w_a_dig;
  logic [3:0]           w_b_dig;
  logic [3:0]           w_d;
  logic                 w_bo;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_last   = (r_idx == c_last_idx);

  // Flag any non-decimal nibble in either incoming operand
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_ok(bus.a[4*i +: 4]) || !bcd_digit_ok(bus.b[4*i +: 4]))
        w_bad = 1'b1;
    end
  end

  // Select the current operand digit pair for the shared digit subtractor
  always_comb begin
    w_a_dig = 4'd0;
    w_b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
  end

  bcd_digit_sub u_digit_sub (
    .a    (w_a_dig),
    .b    (w_b_dig),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; an invalid operand skips RUN entirely
  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = w_bad ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-digit result write-back and borrow chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_idx    <= '0;
      r_borrow <= bus.bin;
      if (w_bad) begin
        r_diff <= '0;
        r_bout <= 1'b0;
        r_err  <= 1'b1;
      end else begin
        r_err  <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_idx == c_idx_w'(i)) r_diff[4*i +: 4] <= w_d;
      end
      r_borrow <= w_bo;
      if (w_last) r_bout <= w_bo;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.err  = r_err;

endmodule
`default_nettype wire
